// File: rtl/coffee_pkg.sv
// Shared definitions for the coffee machine controller and its display controller.
package coffee_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      IDLE       = 3'b000,
      READY      = 3'b001,
      BREW       = 3'b010,
      DONE       = 3'b011,
      NEED_WATER = 3'b100
   } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter and rising-edge pulse.
// The accepted level resets to 1 ("pressed"), so a button held through reset
// must first be seen released before a new press can produce a pulse.
module btn_debounce #(
   parameter int DEBOUNCE_TICKS = 1_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic press
);

   localparam int CNT_W = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

   logic             sync1_reg;
   logic             sync2_reg;
   logic             stable_reg;
   logic             press_reg;
   logic [CNT_W-1:0] cnt_reg;

   // Bring the raw button into the clock domain.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_reg <= 1'b0;
         sync2_reg <= 1'b0;
      end else begin
         sync1_reg <= btn_raw;
         sync2_reg <= sync1_reg;
      end
   end

   // Accept a new level after DEBOUNCE_TICKS consecutive differing samples; pulse on accepted rise.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_reg    <= '0;
         stable_reg <= 1'b1;
         press_reg  <= 1'b0;
      end else begin
         press_reg <= 1'b0;
         if (sync2_reg == stable_reg) begin
            cnt_reg <= '0;
         end else if (cnt_reg == CNT_LAST) begin
            cnt_reg    <= '0;
            stable_reg <= sync2_reg;
            press_reg  <= sync2_reg;
         end else begin
            cnt_reg <= cnt_reg + 1'b1;
         end
      end
   end

   assign press = press_reg;

endmodule

// File: rtl/coffee_ctrl.sv
// Coffee machine controller: cup selection, water bookkeeping and brew/done timing.
module coffee_ctrl
   import coffee_pkg::*;
#(
   parameter int DEBOUNCE_TICKS     = 1_000_000,
   parameter int BREW_TICKS_PER_CUP = 300_000_000,
   parameter int DONE_TICKS         = 200_000_000,
   parameter int WATER_MAX          = 6
) (
   input  logic               clk_100MHz,
   input  logic               reset,
   input  logic               btn_cup,
   input  logic               btn_brew,
   input  logic               btn_refill,
   output logic [STATE_W-1:0] state,
   output logic [1:0]         cup_count,
   output logic [2:0]         water_level,
   output logic               brew_led
);

   // Timer must hold the longest load: three cups of brewing or the done hold.
   localparam longint BREW_MAX  = 3 * longint'(BREW_TICKS_PER_CUP);
   localparam longint TIMER_MAX = (BREW_MAX > longint'(DONE_TICKS)) ? BREW_MAX : longint'(DONE_TICKS);
   localparam int     TW        = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;

   localparam logic [TW-1:0] BREW_PER_CUP = TW'(BREW_TICKS_PER_CUP);
   localparam logic [TW-1:0] DONE_LOAD    = TW'(DONE_TICKS - 1);
   localparam logic [2:0]    WATER_FULL   = 3'(WATER_MAX);

   // Button order: 0 = cup, 1 = brew, 2 = refill.
   logic [2:0] btn_raw;
   logic [2:0] press;

   state_t        state_reg,  state_next;
   logic [1:0]    cup_reg,    cup_next;
   logic [2:0]    water_reg,  water_next;
   logic [TW-1:0] timer_reg,  timer_next;
   logic          led_reg;
   logic [TW-1:0] brew_load;

   assign btn_raw = {btn_refill, btn_brew, btn_cup};

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_btn
         btn_debounce #(
            .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
         ) u_btn (
            .clk    (clk_100MHz),
            .reset  (reset),
            .btn_raw(btn_raw[gi]),
            .press  (press[gi])
         );
      end
   endgenerate

   assign brew_load = {{(TW-2){1'b0}}, cup_reg} * BREW_PER_CUP - TW'(1);

   // Next-state, counter and timer decisions from the current state and press pulses.
   always_comb begin
      state_next = state_reg;
      cup_next   = cup_reg;
      water_next = water_reg;
      timer_next = timer_reg;
      case (state_reg)
         IDLE: begin
            if (press[2]) water_next = WATER_FULL;
            if (press[0]) begin
               cup_next   = 2'd1;
               state_next = READY;
            end
         end
         READY: begin
            if (press[2]) water_next = WATER_FULL;
            if (press[1]) begin
               if (water_reg >= {1'b0, cup_reg}) begin
                  state_next = BREW;
                  timer_next = brew_load;
               end else begin
                  state_next = NEED_WATER;
               end
            end else if (press[0]) begin
               cup_next = (cup_reg == 2'd3) ? 2'd1 : cup_reg + 2'd1;
            end
         end
         BREW: begin
            if (timer_reg == '0) begin
               state_next = DONE;
               water_next = water_reg - {1'b0, cup_reg};
               timer_next = DONE_LOAD;
            end else begin
               timer_next = timer_reg - TW'(1);
            end
         end
         DONE: begin
            if (timer_reg == '0) begin
               state_next = IDLE;
               cup_next   = 2'd0;
            end else begin
               timer_next = timer_reg - TW'(1);
            end
         end
         NEED_WATER: begin
            if (press[2]) begin
               water_next = WATER_FULL;
               state_next = READY;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Register state, counters, timer and the brew indicator.
   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
         cup_reg   <= 2'd0;
         water_reg <= WATER_FULL;
         timer_reg <= '0;
         led_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         cup_reg   <= cup_next;
         water_reg <= water_next;
         timer_reg <= timer_next;
         led_reg   <= (state_next == BREW);
      end
   end

   assign state       = state_reg;
   assign cup_count   = cup_reg;
   assign water_level = water_reg;
   assign brew_led    = led_reg;

endmodule

// File: tb/tb_coffee_ctrl.sv
// Directed testbench for coffee_ctrl with short debounce and brew timings.
module tb_coffee_ctrl;

   logic       clk_100MHz;
   logic       reset;
   logic       btn_cup;
   logic       btn_brew;
   logic       btn_refill;
   logic [2:0] state;
   logic [1:0] cup_count;
   logic [2:0] water_level;
   logic       brew_led;

   int errors = 0;
   int checks = 0;

   coffee_ctrl #(
      .DEBOUNCE_TICKS    (4),
      .BREW_TICKS_PER_CUP(10),
      .DONE_TICKS        (8),
      .WATER_MAX         (6)
   ) dut (
      .clk_100MHz (clk_100MHz),
      .reset      (reset),
      .btn_cup    (btn_cup),
      .btn_brew   (btn_brew),
      .btn_refill (btn_refill),
      .state      (state),
      .cup_count  (cup_count),
      .water_level(water_level),
      .brew_led   (brew_led)
   );

   initial begin
      clk_100MHz = 1'b0;
      forever #5 clk_100MHz = ~clk_100MHz;
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk_100MHz);
   endtask

   // which: 0 = cup, 1 = brew, 2 = refill; hold long enough for one debounced pulse.
   task automatic press(input int which);
      case (which)
         0: btn_cup = 1'b1;
         1: btn_brew = 1'b1;
         default: btn_refill = 1'b1;
      endcase
      wait_cycles(8);
      btn_cup = 1'b0;
      btn_brew = 1'b0;
      btn_refill = 1'b0;
      wait_cycles(8);
   endtask

   task automatic wait_state(input logic [2:0] s, input int budget, output bit ok);
      int n;
      n = 0;
      while (state !== s && n < budget) begin
         @(negedge clk_100MHz);
         n++;
      end
      ok = (state === s);
   endtask

   task automatic apply_reset();
      @(negedge clk_100MHz);
      reset = 1'b1;
      wait_cycles(3);
      reset = 1'b0;
      wait_cycles(10);
   endtask

   task automatic test_reset();
      @(negedge clk_100MHz);
      reset = 1'b1;
      #1;
      checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
      checks++; if (cup_count !== 2'd0) begin errors++; $display("FAIL reset_cup: got %0d want 0", cup_count); end
      checks++; if (water_level !== 3'd6) begin errors++; $display("FAIL reset_water: got %0d want 6", water_level); end
      checks++; if (brew_led !== 1'b0) begin errors++; $display("FAIL reset_led: got %0d want 0", brew_led); end
      wait_cycles(3);
      reset = 1'b0;
      wait_cycles(10);
      $display("test_reset: state=%0d cup=%0d water=%0d led=%0d", state, cup_count, water_level, brew_led);
   endtask

   task automatic test_cup_select();
      press(0);
      checks++; if (state !== 3'd1) begin errors++; $display("FAIL cup1_state: got %0d want 1", state); end
      checks++; if (cup_count !== 2'd1) begin errors++; $display("FAIL cup1_count: got %0d want 1", cup_count); end
      press(0);
      checks++; if (state !== 3'd1) begin errors++; $display("FAIL cup2_state: got %0d want 1", state); end
      checks++; if (cup_count !== 2'd2) begin errors++; $display("FAIL cup2_count: got %0d want 2", cup_count); end
      checks++; if (water_level !== 3'd6) begin errors++; $display("FAIL cup2_water: got %0d want 6", water_level); end
      $display("test_cup_select: state=%0d cup=%0d water=%0d", state, cup_count, water_level);
   endtask

   task automatic test_brew_cycle();
      bit ok;
      int n, m, led_bad;
      btn_brew = 1'b1;
      wait_state(3'd2, 20, ok);
      checks++; if (!ok) begin errors++; $display("FAIL brew_enter: state=%0d want 2", state); end
      n = 0;
      led_bad = 0;
      while (state === 3'd2 && n < 100) begin
         if (brew_led !== 1'b1) led_bad++;
         n++;
         if (n == 8) btn_brew = 1'b0;
         @(negedge clk_100MHz);
      end
      btn_brew = 1'b0;
      checks++; if (n != 20) begin errors++; $display("FAIL brew_len: got %0d cycles want 20", n); end
      checks++; if (led_bad != 0) begin errors++; $display("FAIL brew_led: %0d cycles low want 0", led_bad); end
      checks++; if (state !== 3'd3) begin errors++; $display("FAIL done_state: got %0d want 3", state); end
      checks++; if (water_level !== 3'd4) begin errors++; $display("FAIL done_water: got %0d want 4", water_level); end
      checks++; if (brew_led !== 1'b0) begin errors++; $display("FAIL done_led: got %0d want 0", brew_led); end
      m = 0;
      while (state === 3'd3 && m < 100) begin
         m++;
         @(negedge clk_100MHz);
      end
      checks++; if (m != 8) begin errors++; $display("FAIL done_len: got %0d cycles want 8", m); end
      checks++; if (state !== 3'd0) begin errors++; $display("FAIL after_done_state: got %0d want 0", state); end
      checks++; if (cup_count !== 2'd0) begin errors++; $display("FAIL after_done_cup: got %0d want 0", cup_count); end
      wait_cycles(8);
      $display("test_brew_cycle: brew=%0d done=%0d water=%0d", n, m, water_level);
   endtask

   task automatic test_need_water();
      bit ok;
      press(0); press(0); press(0);
      press(1);
      wait_state(3'd0, 100, ok);
      checks++; if (!ok) begin errors++; $display("FAIL nw_drain_idle: state=%0d want 0", state); end
      checks++; if (water_level !== 3'd1) begin errors++; $display("FAIL nw_drain_water: got %0d want 1", water_level); end
      press(0); press(0); press(0);
      checks++; if (cup_count !== 2'd3) begin errors++; $display("FAIL nw_cup3: got %0d want 3", cup_count); end
      press(1);
      checks++; if (state !== 3'd4) begin errors++; $display("FAIL nw_state: got %0d want 4", state); end
      checks++; if (cup_count !== 2'd3) begin errors++; $display("FAIL nw_cup_held: got %0d want 3", cup_count); end
      press(0);
      press(1);
      checks++; if (state !== 3'd4 || cup_count !== 2'd3) begin errors++; $display("FAIL nw_ignore: state=%0d cup=%0d want 4/3", state, cup_count); end
      press(2);
      checks++; if (state !== 3'd1) begin errors++; $display("FAIL refill_state: got %0d want 1", state); end
      checks++; if (water_level !== 3'd6) begin errors++; $display("FAIL refill_water: got %0d want 6", water_level); end
      checks++; if (cup_count !== 2'd3) begin errors++; $display("FAIL refill_cup: got %0d want 3", cup_count); end
      press(0);
      checks++; if (cup_count !== 2'd1) begin errors++; $display("FAIL cup_wrap: got %0d want 1", cup_count); end
      $display("test_need_water: state=%0d cup=%0d water=%0d", state, cup_count, water_level);
   endtask

   task automatic test_bounce();
      apply_reset();
      press(0);
      checks++; if (cup_count !== 2'd1) begin errors++; $display("FAIL bounce_start: got %0d want 1", cup_count); end
      repeat (4) begin
         btn_cup = 1'b1; wait_cycles(3);
         btn_cup = 1'b0; wait_cycles(2);
      end
      checks++; if (cup_count !== 2'd1) begin errors++; $display("FAIL bounce_ignored: got %0d want 1", cup_count); end
      btn_cup = 1'b1;
      wait_cycles(50);
      checks++; if (cup_count !== 2'd2) begin errors++; $display("FAIL bounce_held: got %0d want 2", cup_count); end
      btn_cup = 1'b0;
      wait_cycles(10);
      checks++; if (cup_count !== 2'd2 || state !== 3'd1) begin errors++; $display("FAIL bounce_release: cup=%0d state=%0d want 2/1", cup_count, state); end
      $display("test_bounce: cup=%0d", cup_count);
   endtask

   task automatic test_same_cycle();
      bit ok;
      apply_reset();
      press(0);
      btn_cup = 1'b1;
      btn_brew = 1'b1;
      wait_state(3'd2, 20, ok);
      checks++; if (!ok) begin errors++; $display("FAIL same_state: got %0d want 2", state); end
      checks++; if (cup_count !== 2'd1) begin errors++; $display("FAIL same_cup: got %0d want 1", cup_count); end
      wait_cycles(8);
      btn_cup = 1'b0;
      btn_brew = 1'b0;
      wait_state(3'd0, 100, ok);
      checks++; if (!ok || water_level !== 3'd5) begin errors++; $display("FAIL same_end: state=%0d water=%0d want 0/5", state, water_level); end
      wait_cycles(8);
      press(2);
      checks++; if (state !== 3'd0 || water_level !== 3'd6) begin errors++; $display("FAIL idle_refill: state=%0d water=%0d want 0/6", state, water_level); end
      $display("test_same_cycle: state=%0d cup=%0d water=%0d", state, cup_count, water_level);
   endtask

   task automatic test_reset_mid_brew();
      bit ok;
      bit seen_done;
      apply_reset();
      press(0);
      btn_brew = 1'b1;
      wait_state(3'd2, 20, ok);
      checks++; if (!ok) begin errors++; $display("FAIL midrst_enter: state=%0d want 2", state); end
      wait_cycles(4);
      reset = 1'b1;
      btn_brew = 1'b0;
      #1;
      checks++; if (state !== 3'd0 || cup_count !== 2'd0 || water_level !== 3'd6 || brew_led !== 1'b0)
         begin errors++; $display("FAIL midrst_outputs: %0d/%0d/%0d/%0d want 0/0/6/0", state, cup_count, water_level, brew_led); end
      wait_cycles(3);
      reset = 1'b0;
      seen_done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk_100MHz);
         if (state === 3'd3) seen_done = 1'b1;
      end
      checks++; if (seen_done || state !== 3'd0) begin errors++; $display("FAIL midrst_after: done_seen=%0d state=%0d want 0/0", seen_done, state); end
      $display("test_reset_mid_brew: state=%0d water=%0d", state, water_level);
   endtask

   task automatic test_held_through_reset();
      btn_cup = 1'b1;
      apply_reset();
      wait_cycles(30);
      checks++; if (state !== 3'd0 || cup_count !== 2'd0) begin errors++; $display("FAIL held_reset: state=%0d cup=%0d want 0/0", state, cup_count); end
      btn_cup = 1'b0;
      wait_cycles(10);
      press(0);
      checks++; if (state !== 3'd1 || cup_count !== 2'd1) begin errors++; $display("FAIL held_repress: state=%0d cup=%0d want 1/1", state, cup_count); end
      $display("test_held_through_reset: state=%0d cup=%0d", state, cup_count);
   endtask

   initial begin
      reset = 1'b0;
      btn_cup = 1'b0;
      btn_brew = 1'b0;
      btn_refill = 1'b0;
      test_reset();
      test_cup_select();
      test_brew_cycle();
      test_need_water();
      test_bounce();
      test_same_cycle();
      test_reset_mid_brew();
      test_held_through_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/coffee_ctrl.md
COFFEE_CTRL -- requirements
Module: coffee_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_TICKS, default 1_000_000, meaning the number of consecutive stable clock cycles (10 ms) required before a button level is accepted.
REQ-002 SHALL have parameter BREW_TICKS_PER_CUP, default 300_000_000, meaning the brew duration per cup in clock cycles (3 s).
REQ-003 SHALL have parameter DONE_TICKS, default 200_000_000, meaning the DONE display hold time in clock cycles (2 s).
REQ-004 SHALL have parameter WATER_MAX, default 6, meaning the full-reservoir level in cup units (range 1..7).
REQ-005 SHALL have port clk_100MHz, input, 1 bit: 100 MHz system clock; the block uses this single clock.
REQ-006 SHALL have port reset, input, 1 bit: active-high asynchronous reset.
REQ-007 SHALL have port btn_cup, input, 1 bit: raw cup-select button.
REQ-008 SHALL have port btn_brew, input, 1 bit: raw brew-start button.
REQ-009 SHALL have port btn_refill, input, 1 bit: raw reservoir-refilled button.
REQ-010 SHALL have port state, output, 3 bits: current FSM state, fed to the display controller.
REQ-011 SHALL have port cup_count, output, 2 bits: selected cups 0..3, fed to the display controller.
REQ-012 SHALL have port water_level, output, 3 bits: remaining water in cup units.
REQ-013 SHALL have port brew_led, output, 1 bit: high exactly while state==BREW.

Function
REQ-014 Each button input SHALL pass a 2-FF synchronizer and a debouncer, then produce a one-cycle press pulse on the debounced rising edge; raw-to-pulse latency SHALL be at most DEBOUNCE_TICKS+3 cycles, and holding a button SHALL generate exactly one pulse.
REQ-015 State encoding SHALL be IDLE=000, READY=001, BREW=010, DONE=011, NEED_WATER=100; codes 101..111 SHALL return to IDLE on the next clock.
REQ-016 The effect of a press pulse registered in cycle N SHALL be visible on all outputs in cycle N+1.
REQ-017 In IDLE, a cup pulse SHALL set cup_count=1 and enter READY; the brew pulse SHALL be ignored.
REQ-018 In READY, a cup pulse SHALL step cup_count 1->2->3->1.
REQ-019 In READY, a brew pulse with water_level>=cup_count SHALL enter BREW and load the brew timer with cup_count*BREW_TICKS_PER_CUP-1.
REQ-020 In READY, a brew pulse with water_level<cup_count SHALL enter NEED_WATER with cup_count held.
REQ-021 In READY, when brew and cup pulses occur in the same cycle, the brew pulse SHALL take priority and the cup pulse SHALL be dropped.
REQ-022 In BREW, the timer SHALL decrement once per cycle; at 0 the block SHALL enter DONE, subtract cup_count from water_level, and load the DONE timer with DONE_TICKS-1.
REQ-023 In BREW, all button pulses SHALL be ignored.
REQ-024 In DONE, the timer SHALL count to 0, then the block SHALL enter IDLE with cup_count=0; button pulses SHALL be ignored.
REQ-025 In NEED_WATER, a refill pulse SHALL set water_level=WATER_MAX and enter READY; cup and brew pulses SHALL be ignored.
REQ-026 In IDLE and READY, a refill pulse SHALL set water_level=WATER_MAX without changing state.
REQ-027 Timer width SHALL be $clog2(3*BREW_TICKS_PER_CUP) bits or more (at least 30 bits at defaults), with no overflow.
REQ-028 water_level SHALL never underflow; this follows from REQ-019 and REQ-020.
REQ-029 All outputs SHALL be registered with no combinational path from inputs.

Reset
REQ-030 While reset is high, the outputs SHALL be state=IDLE, cup_count=0, water_level=WATER_MAX, brew_led=0, and all timers, debouncers and synchronizers SHALL be cleared, asynchronously and regardless of current state, including mid-BREW.
REQ-031 After reset deasserts, a button already held SHALL NOT produce a pulse until it is released and pressed again.

Structure
REQ-032 The shared package coffee_pkg SHALL hold the state encodings IDLE..NEED_WATER and the 3-bit state width, shared with the display controller.
REQ-033 The sub-module btn_debounce (synchronizer, stability counter, edge pulse; parameter DEBOUNCE_TICKS) SHALL be instantiated three times.
REQ-034 The FSM, cup counter, water counter and timers SHALL reside in coffee_ctrl.

Verification (DEBOUNCE_TICKS=4, BREW_TICKS_PER_CUP=10, DONE_TICKS=8, WATER_MAX=6)
REQ-035 Bench SHALL cover: reset, then cup pressed x2 -> state=001, cup_count=2, water_level=6.
REQ-036 Bench SHALL cover: cup_count=2, then brew -> state=010 for exactly 20 cycles, brew_led=1, then state=011 and water_level=4 for 8 cycles, then state=000 and cup_count=0.
REQ-037 Bench SHALL cover: water_level=1, cup_count=3, then brew -> state=100 with cup_count=3; then refill -> state=001 and water_level=6.
REQ-038 Bench SHALL cover: button bouncing 3-cycle pulses, then held 50 cycles -> exactly one cup increment.
REQ-039 Bench SHALL cover: brew and cup pulses in the same cycle in READY with cup_count=1 -> state=010 and cup_count=1.
REQ-040 Bench SHALL cover: reset asserted at brew cycle 5 -> outputs immediately 000/0/6/0, and no DONE afterward.
